// File: rtl/btn_pkg.sv
// Shared types and default sizes for the multi-channel button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } btn_state_e;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_CNTR_WIDTH = 4;
    localparam int DEF_HOLD_WIDTH = 8;

endpackage

// File: rtl/multi_btn_debounce_if.sv
// Button bus: CE qualifies every counter step, BTN_IN is raw; all outputs are registered levels/pulses.
interface multi_btn_debounce_if import btn_pkg::*; #(
    parameter int N_CH = DEF_N_CH
) ();

    logic                  CE;
    logic [N_CH-1:0]       BTN_IN;
    logic [N_CH-1:0]       BTN_OUT;
    logic [N_CH-1:0]       RISE_CEO;
    logic [N_CH-1:0]       FALL_CEO;
    logic [N_CH-1:0]       HOLD_CEO;
    logic [N_CH-1:0][1:0]  DBG_STATE;

    modport master (
        output CE, BTN_IN,
        input  BTN_OUT, RISE_CEO, FALL_CEO, HOLD_CEO, DBG_STATE
    );

    modport slave (
        input  CE, BTN_IN,
        output BTN_OUT, RISE_CEO, FALL_CEO, HOLD_CEO, DBG_STATE
    );

endinterface

// File: rtl/btn_ch_fltr.sv
// One button channel: 2-flop synchronizer, debounce filter and press/hold FSM.
// BTN_AUTOREPEAT_EN defined: HOLD pulses repeat every hold period while held; otherwise one per press.
module btn_ch_fltr import btn_pkg::*; #(
    parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
    parameter int HOLD_WIDTH = DEF_HOLD_WIDTH
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic       i_btn,
    output logic       o_btn,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_hold,
    output btn_state_e o_state
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_btn;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_hold;
    logic [CNTR_WIDTH-1:0] r_fcnt;
    logic [HOLD_WIDTH-1:0] r_hcnt;
    btn_state_e            r_state;

    logic w_diff;
    logic w_fdone;
    logic w_hdone;

    assign w_diff  = r_sync2 ^ r_btn;
    assign w_fdone = i_ce & w_diff & (&r_fcnt);
    assign w_hdone = i_ce & (&r_hcnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_btn   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_hold  <= 1'b0;
            r_fcnt  <= '0;
            r_hcnt  <= '0;
            r_state <= RELEASED;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_hold <= 1'b0;

            // Synchronizer advances on CE so latency is measured purely in CE ticks.
            if (i_ce) begin
                r_sync1 <= i_btn;
                r_sync2 <= r_sync1;
            end

            if (!w_diff || w_fdone) begin
                r_fcnt <= '0;
            end else if (i_ce) begin
                r_fcnt <= r_fcnt + 1'b1;
            end

            if (w_fdone) begin
                r_btn  <= r_sync2;
                r_rise <= r_sync2;
                r_fall <= ~r_sync2;
            end

            // State mirrors r_btn, so w_fdone means press in RELEASED and release elsewhere.
            case (r_state)
                RELEASED: begin
                    r_hcnt <= '0;
                    if (w_fdone) begin
                        r_state <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (w_fdone) begin
                        r_state <= RELEASED;
                        r_hcnt  <= '0;
                    end else if (w_hdone) begin
                        r_hold  <= 1'b1;
                        r_state <= HELD;
`ifdef BTN_AUTOREPEAT_EN
                        r_hcnt  <= '0;
`endif
                    end else if (i_ce) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_fdone) begin
                        r_state <= RELEASED;
                        r_hcnt  <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (w_hdone) begin
                        r_hold <= 1'b1;
                        r_hcnt <= '0;
                    end else if (i_ce) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= RELEASED;
                    r_hcnt  <= '0;
                end
            endcase
        end
    end

    assign o_btn   = r_btn;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_hold  = r_hold;
    assign o_state = r_state;

endmodule

// File: rtl/multi_btn_debounce.sv
// N_CH independent debounced buttons with press/release/long-press pulses.
// Build with BTN_AUTOREPEAT_EN defined to make long-press pulses auto-repeat while held.
module multi_btn_debounce import btn_pkg::*; #(
    parameter int N_CH       = DEF_N_CH,
    parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
    parameter int HOLD_WIDTH = DEF_HOLD_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    multi_btn_debounce_if.slave  bus
);

    logic [N_CH-1:0] w_btn;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_hold;
    btn_state_e      w_state [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_ch_fltr #(
            .CNTR_WIDTH (CNTR_WIDTH),
            .HOLD_WIDTH (HOLD_WIDTH)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_ce    (bus.CE),
            .i_btn   (bus.BTN_IN[g]),
            .o_btn   (w_btn[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g]),
            .o_hold  (w_hold[g]),
            .o_state (w_state[g])
        );

        assign bus.DBG_STATE[g] = w_state[g];
    end

    assign bus.BTN_OUT  = w_btn;
    assign bus.RISE_CEO = w_rise;
    assign bus.FALL_CEO = w_fall;
    assign bus.HOLD_CEO = w_hold;

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Bench for multi_btn_debounce: directed latency/glitch/hold/reset cases, then random stimulus vs a sliding-window model.
module tb_multi_btn_debounce;

    localparam int N_CH = 4;
    localparam int CW   = 4;
    localparam int HW   = 4;
    localparam int FILT = 1 << CW;
    localparam int HOLD = 1 << HW;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    multi_btn_debounce_if #(.N_CH(N_CH)) bus ();

    multi_btn_debounce #(
        .N_CH       (N_CH),
        .CNTR_WIDTH (CW),
        .HOLD_WIDTH (HW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raw samples taken on CE ticks; a channel flips once the 16 samples
    // that have cleared the synchronizer all disagree with its debounced level.
    logic [N_CH-1:0] hist [$];
    logic [N_CH-1:0] m_out, m_rise, m_fall, m_hold, m_held;
    int              tick;
    int              press_tick [N_CH];

    task automatic model_edge(input logic rst, input logic ce, input logic [N_CH-1:0] btn);
        m_rise = '0;
        m_fall = '0;
        m_hold = '0;
        if (rst) begin
            m_out  = '0;
            m_held = '0;
            tick   = 0;
            hist.delete();
            for (int k = 0; k < FILT + 1; k++) hist.push_back('0);
            return;
        end
        if (!ce) return;
        tick++;
        for (int ch = 0; ch < N_CH; ch++) begin
            bit all_diff;
            int el;
            all_diff = 1'b1;
            for (int k = 0; k < FILT; k++) begin
                if (hist[k][ch] == m_out[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                if (m_out[ch]) begin
                    m_fall[ch] = 1'b1;
                    m_held[ch] = 1'b0;
                end else begin
                    m_rise[ch]     = 1'b1;
                    press_tick[ch] = tick;
                end
                m_out[ch] = ~m_out[ch];
            end else if (m_out[ch]) begin
                el = tick - press_tick[ch];
`ifdef BTN_AUTOREPEAT_EN
                if (el % HOLD == 0) m_hold[ch] = 1'b1;
`else
                if (el == HOLD) m_hold[ch] = 1'b1;
`endif
                if (m_hold[ch]) m_held[ch] = 1'b1;
            end
        end
        hist.push_back(btn);
        void'(hist.pop_front());
    endtask

    function automatic logic [2*N_CH-1:0] exp_state();
        logic [2*N_CH-1:0] s;
        s = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!m_out[ch])     s[2*ch +: 2] = 2'd0;
            else if (m_held[ch]) s[2*ch +: 2] = 2'd2;
            else                 s[2*ch +: 2] = 2'd1;
        end
        return s;
    endfunction

    logic [N_CH-1:0] btn_v;
    logic            ce_v;

    task automatic step(input logic rst);
        @(negedge CLK);
        RST        = rst;
        bus.CE     = ce_v;
        bus.BTN_IN = btn_v;
        @(posedge CLK);
        model_edge(rst, ce_v, btn_v);
        #1;
        check("btn_out",  bus.BTN_OUT,  m_out);
        check("rise_ceo", bus.RISE_CEO, m_rise);
        check("fall_ceo", bus.FALL_CEO, m_fall);
        check("hold_ceo", bus.HOLD_CEO, m_hold);
        check("state",    bus.DBG_STATE, exp_state());
    endtask

    int lat, ticks, seen, rise_c, fall_c, first_hold, n_hold;

    initial begin
        RST        = 1'b1;
        bus.CE     = 1'b0;
        bus.BTN_IN = '0;
        btn_v      = '0;
        ce_v       = 1'b1;
        step(1'b1);
        step(1'b1);

        // Clean press on ch0.
        btn_v[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0);
            if (lat == 0 && bus.BTN_OUT[0]) begin
                lat = i;
                check("rise_pulse_ch0", bus.RISE_CEO[0], 1'b1);
            end
        end
        check("rise_latency_ch0", lat, 2 + FILT);
        btn_v[0] = 1'b0;
        for (int i = 0; i < 30; i++) step(1'b0);

        // Short glitch on ch1 must be swallowed.
        seen = 0;
        btn_v[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) btn_v[1] = 1'b0;
            step(1'b0);
            if (bus.BTN_OUT[1] || bus.RISE_CEO[1] || bus.FALL_CEO[1]) seen++;
        end
        check("glitch_ch1", seen, 0);

        // Long press on ch2: 60 cycles high, then release.
        rise_c = 0; fall_c = 0; first_hold = 0; n_hold = 0;
        btn_v[2] = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 61) btn_v[2] = 1'b0;
            step(1'b0);
            if (bus.RISE_CEO[2]) rise_c = i;
            if (bus.FALL_CEO[2]) fall_c = i;
            if (bus.HOLD_CEO[2]) begin
                n_hold++;
                if (first_hold == 0) first_hold = i;
            end
        end
        check("hold_rise_cycle", rise_c, 2 + FILT);
        check("hold_fall_cycle", fall_c, 61 + FILT + 1);
        check("hold_delay", first_hold - rise_c, HOLD);
`ifdef BTN_AUTOREPEAT_EN
        check("hold_count", n_hold, 3);
`else
        check("hold_count", n_hold, 1);
`endif

        // CE asserted one cycle in four on ch3.
        btn_v[3] = 1'b1;
        ticks = 0; lat = 0;
        for (int i = 0; i < 120; i++) begin
            ce_v = (i % 4 == 0);
            step(1'b0);
            if (ce_v) ticks++;
            if (lat == 0 && bus.BTN_OUT[3]) begin
                lat = ticks;
                check("ce_edge_ch3", ce_v, 1'b1);
            end
        end
        check("ce_latency_ch3", lat, 2 + FILT);
        ce_v = 1'b1;
        btn_v[3] = 1'b0;
        for (int i = 0; i < 30; i++) step(1'b0);

        // Reset in the middle of a filter run, button kept pressed through it.
        btn_v[0] = 1'b1;
        for (int i = 0; i < 11; i++) step(1'b0);
        step(1'b1);
        step(1'b1);
        check("rst_btn_out", bus.BTN_OUT, '0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0);
            if (lat == 0 && bus.RISE_CEO[0]) lat = i;
        end
        check("rst_rise_latency", lat, 2 + FILT);
        btn_v = '0;
        for (int i = 0; i < 30; i++) step(1'b0);

        // Random phase: bouncy inputs, CE first always on then sparse, rare resets.
        for (int i = 0; i < 4000; i++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(0, 19) == 0) btn_v[ch] = ~btn_v[ch];
            end
            ce_v = (i < 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 999) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
